onchip_ram_rr_arbiter: RTL and testbench

- Shares one 32-bit port (s1) of the 8192-word on-chip RAM between two Avalon-MM requesters, m0 and m1.
- Arbitrates round-robin, one transaction per cycle, and drives the RAM's address, chipselect, write, byteenable and writedata.
- Tracks outstanding reads and returns readdata/readdatavalid to the requester that issued each read.
- Optional post-reset zero-fill sweep of the whole RAM.

---
 rtl/onchip_ram_arb_pkg.sv | 15 +
 rtl/onchip_ram_rsp_tracker.sv | 27 ++
 rtl/onchip_ram_rr_arbiter.sv | 103 ++++++++++
 tb/tb_onchip_ram_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_ram_arb_pkg.sv
// onchip_ram_arb_pkg: shared constants and types for the on-chip RAM round-robin arbiter
package onchip_ram_arb_pkg;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef logic owner_t;

    typedef enum logic {INIT, ARB} state_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rsp_tag_t;
endpackage

// File: rtl/onchip_ram_rsp_tracker.sv
// onchip_ram_rsp_tracker: read-response tag pipeline matching the RAM read latency
module onchip_ram_rsp_tracker
    import onchip_ram_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  rsp_tag_t push_tag,
    output rsp_tag_t tail_tag
);
    rsp_tag_t pipe_q [DEPTH];
    rsp_tag_t pipe_d [DEPTH];

    // shift the newest tag in at the head, everything else moves one stage on
    always_comb begin
        pipe_d[0] = push_tag;
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end

    // tag registers; reset drops every in-flight read
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) pipe_q[i] <= reset ? '0 : pipe_d[i];
    end

    assign tail_tag = pipe_q[DEPTH-1];
endmodule

// File: rtl/onchip_ram_rr_arbiter.sv
// onchip_ram_rr_arbiter: round-robin share of one on-chip RAM port between two Avalon-MM requesters
module onchip_ram_rr_arbiter #(
    parameter int ADDR_W        = onchip_ram_arb_pkg::ADDR_W,
    parameter int DATA_W        = onchip_ram_arb_pkg::DATA_W,
    parameter int BE_W          = onchip_ram_arb_pkg::BE_W,
    parameter int READ_LATENCY  = 1,
    parameter int ZERO_ON_RESET = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);
    import onchip_ram_arb_pkg::*;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    owner_t            last_q, last_d;
    logic              req0, req1, arb, init, grant0, grant1;
    rsp_tag_t          push_tag, tail_tag;

    // state, sweep counter and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (ZERO_ON_RESET != 0) ? INIT : ARB;
            sweep_q <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            last_q  <= last_d;
        end
    end

    // grant: a lone requester wins, a tie goes to whoever was not granted last
    always_comb begin
        arb           = ~reset & (state_q == ARB);
        init          = ~reset & (state_q == INIT);
        req0          = m0_read | m0_write;
        req1          = m1_read | m1_write;
        grant0        = arb & req0 & (~req1 | last_q);
        grant1        = arb & req1 & (~req0 | ~last_q);
        push_tag.valid = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);
        push_tag.owner = grant1;
    end

    // next state: sweep one word per cycle, leave INIT after the last word
    always_comb begin
        state_d = (state_q == INIT && &sweep_q) ? ARB : state_q;
        sweep_d = (state_q == INIT) ? sweep_q + 1'b1 : sweep_q;
        last_d  = (grant0 | grant1) ? grant1 : last_q;
    end

    // outputs: the granted request (or the zero-fill sweep) drives the RAM this cycle
    always_comb begin
        mem_chipselect   = init | grant0 | grant1;
        mem_write        = init | (grant0 & m0_write) | (grant1 & m1_write);
        mem_address      = init ? sweep_q : (grant1 ? m1_address : m0_address);
        mem_byteenable   = init ? '1 : (grant1 ? m1_byteenable : m0_byteenable);
        mem_writedata    = init ? '0 : (grant1 ? m1_writedata : m0_writedata);
        m0_waitrequest   = reset | init | (req0 & ~grant0);
        m1_waitrequest   = reset | init | (req1 & ~grant1);
        m0_readdatavalid = ~reset & tail_tag.valid & ~tail_tag.owner;
        m1_readdatavalid = ~reset & tail_tag.valid & tail_tag.owner;
        m0_readdata      = mem_readdata;
        m1_readdata      = mem_readdata;
    end

    // a requester raising read and write together is a protocol error; the write wins
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(m0_read && m0_write));
            assert (!(m1_read && m1_write));
        end
    end

    onchip_ram_rsp_tracker #(.DEPTH(READ_LATENCY)) u_rsp (
        .clk      (clk),
        .reset    (reset),
        .push_tag (push_tag),
        .tail_tag (tail_tag)
    );
endmodule

// File: tb/tb_onchip_ram_rr_arbiter.sv
// tb_onchip_ram_rr_arbiter: directed checks of arbitration, read return, byte lanes, reset and zero-fill
module tb_onchip_ram_rr_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_writedata, m1_writedata;

    logic        a_m0_waitrequest, a_m0_readdatavalid, a_m1_waitrequest, a_m1_readdatavalid;
    logic [31:0] a_m0_readdata, a_m1_readdata, a_mem_writedata, a_mem_readdata;
    logic [12:0] a_mem_address;
    logic        a_mem_chipselect, a_mem_write;
    logic [3:0]  a_mem_byteenable;

    logic        b_m0_waitrequest, b_m0_readdatavalid, b_m1_waitrequest, b_m1_readdatavalid;
    logic [31:0] b_m0_readdata, b_m1_readdata, b_mem_writedata, b_mem_readdata;
    logic [12:0] b_mem_address;
    logic        b_mem_chipselect, b_mem_write;
    logic [3:0]  b_mem_byteenable;

    logic [31:0] ram_a [8192];
    logic [31:0] ram_b [8192];
    logic [12:0] a_q, b_q;
    bit          filled;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onchip_ram_rr_arbiter #(.READ_LATENCY(1), .ZERO_ON_RESET(0)) dut_a (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(a_m0_waitrequest), .m0_readdata(a_m0_readdata), .m0_readdatavalid(a_m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(a_m1_waitrequest), .m1_readdata(a_m1_readdata), .m1_readdatavalid(a_m1_readdatavalid),
        .mem_address(a_mem_address), .mem_chipselect(a_mem_chipselect), .mem_write(a_mem_write),
        .mem_byteenable(a_mem_byteenable), .mem_writedata(a_mem_writedata), .mem_readdata(a_mem_readdata)
    );

    onchip_ram_rr_arbiter #(.READ_LATENCY(1), .ZERO_ON_RESET(1)) dut_b (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(b_m0_waitrequest), .m0_readdata(b_m0_readdata), .m0_readdatavalid(b_m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(b_m1_waitrequest), .m1_readdata(b_m1_readdata), .m1_readdatavalid(b_m1_readdatavalid),
        .mem_address(b_mem_address), .mem_chipselect(b_mem_chipselect), .mem_write(b_mem_write),
        .mem_byteenable(b_mem_byteenable), .mem_writedata(b_mem_writedata), .mem_readdata(b_mem_readdata)
    );

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

    // RAM models: registered address, unregistered data out, preloaded with a nonzero pattern
    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 8192; i++) begin
                ram_a[i] <= pat(i);
                ram_b[i] <= pat(i);
            end
            filled <= 1'b1;
        end else begin
            if (a_mem_chipselect && a_mem_write)
                ram_a[a_mem_address] <= merge(ram_a[a_mem_address], a_mem_writedata, a_mem_byteenable);
            if (b_mem_chipselect && b_mem_write)
                ram_b[b_mem_address] <= merge(ram_b[b_mem_address], b_mem_writedata, b_mem_byteenable);
        end
        a_q <= a_mem_address;
        b_q <= b_mem_address;
    end

    assign a_mem_readdata = ram_a[a_q];
    assign b_mem_readdata = ram_b[b_q];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    endtask

    task automatic drv(input int r, input logic rd, input logic wr, input logic [12:0] ad,
                       input logic [3:0] be, input logic [31:0] wd);
        if (r == 0) begin
            m0_read = rd; m0_write = wr; m0_address = ad; m0_byteenable = be; m0_writedata = wd;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = ad; m1_byteenable = be; m1_writedata = wd;
        end
    endtask

    initial begin
        int n;
        logic exp0;
        logic [12:0] prev;
        reset = 1'b1;
        idle();
        drv(0, 1, 0, 13'h0, 4'hF, 0);
        drv(1, 1, 0, 13'h100, 4'hF, 0);
        repeat (2) @(posedge clk);
        #1;
        // reset holds everyone off the RAM even with requests pending
        @(negedge clk);
        check("rst_m0_wait", a_m0_waitrequest, 1);
        check("rst_m1_wait", a_m1_waitrequest, 1);
        check("rst_cs", a_mem_chipselect, 0);
        check("rst_we", a_mem_write, 0);
        check("rst_m0_rdv", a_m0_readdatavalid, 0);
        check("rst_b_wait", b_m0_waitrequest, 1);
        nxt(); reset = 1'b0; idle();
        @(negedge clk);
        check("idle_m0_rdv", a_m0_readdatavalid, 0);
        check("idle_m1_rdv", a_m1_readdatavalid, 0);
        check("idle_cs", a_mem_chipselect, 0);
        // first tie goes to m0
        nxt(); drv(0, 1, 0, 13'h0, 4'hF, 0); drv(1, 1, 0, 13'h100, 4'hF, 0);
        @(negedge clk);
        check("tie_m0_wait", a_m0_waitrequest, 0);
        check("tie_m1_wait", a_m1_waitrequest, 1);
        check("tie_addr", a_mem_address, 0);
        check("tie_cs", a_mem_chipselect, 1);
        check("tie_we", a_mem_write, 0);
        nxt(); idle();
        @(negedge clk);
        check("tie_m0_rdv", a_m0_readdatavalid, 1);
        check("tie_m0_data", a_m0_readdata, pat(0));
        check("tie_m1_rdv", a_m1_readdatavalid, 0);
        // write then read back
        nxt(); drv(0, 0, 1, 13'h10, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        check("wr_cs", a_mem_chipselect, 1);
        check("wr_we", a_mem_write, 1);
        check("wr_addr", a_mem_address, 13'h10);
        check("wr_data", a_mem_writedata, 32'hDEADBEEF);
        nxt(); idle(); drv(0, 1, 0, 13'h10, 4'hF, 0);
        @(negedge clk);
        check("rd_wait", a_m0_waitrequest, 0);
        check("wr_no_rdv", a_m0_readdatavalid, 0);
        nxt(); idle();
        @(negedge clk);
        check("rd_rdv", a_m0_readdatavalid, 1);
        check("rd_data", a_m0_readdata, 32'hDEADBEEF);
        check("rd_m1_rdv", a_m1_readdatavalid, 0);
        // m1 preloads a word for the byte-lane test; m1 becomes last granted
        nxt(); drv(1, 0, 1, 13'h200, 4'hF, 32'hAAAAAAAA);
        @(negedge clk);
        check("m1wr_wait", a_m1_waitrequest, 0);
        check("m1wr_we", a_mem_write, 1);
        // continuous contention: strict alternation starting with m0
        prev = '0;
        for (int k = 0; k < 12; k++) begin
            nxt();
            drv(0, 1, 0, 13'((k + 1) / 2), 4'hF, 0);
            drv(1, 1, 0, 13'(32'h100 + k / 2), 4'hF, 0);
            exp0 = (k % 2 == 0);
            @(negedge clk);
            check("alt_m0_wait", a_m0_waitrequest, !exp0);
            check("alt_m1_wait", a_m1_waitrequest, exp0);
            check("alt_addr", a_mem_address, exp0 ? 13'(k / 2) : 13'(32'h100 + k / 2));
            if (k > 0) begin
                check("alt_m0_rdv", a_m0_readdatavalid, !exp0);
                check("alt_m1_rdv", a_m1_readdatavalid, exp0);
                check("alt_data", a_m0_readdata, pat(int'(prev)));
            end
            prev = exp0 ? 13'(k / 2) : 13'(32'h100 + k / 2);
        end
        nxt(); idle();
        @(negedge clk);
        check("alt_last_m1_rdv", a_m1_readdatavalid, 1);
        check("alt_last_m0_rdv", a_m0_readdatavalid, 0);
        check("alt_last_data", a_m1_readdata, pat(32'h105));
        // partial byte-lane write
        nxt(); drv(1, 0, 1, 13'h200, 4'h3, 32'h11223344);
        @(negedge clk);
        check("be_mem_be", a_mem_byteenable, 4'h3);
        nxt(); drv(1, 1, 0, 13'h200, 4'hF, 0);
        nxt(); idle();
        @(negedge clk);
        check("be_rdv", a_m1_readdatavalid, 1);
        check("be_data", a_m1_readdata, 32'hAAAA3344);
        // reset the cycle after an accepted read discards the response
        nxt(); drv(0, 1, 0, 13'h10, 4'hF, 0);
        @(negedge clk);
        check("rr_wait", a_m0_waitrequest, 0);
        nxt(); idle(); reset = 1'b1;
        @(negedge clk);
        check("rr_m0_rdv", a_m0_readdatavalid, 0);
        check("rr_m1_rdv", a_m1_readdatavalid, 0);
        nxt(); reset = 1'b0;
        @(negedge clk);
        check("rr_post_m0_rdv", a_m0_readdatavalid, 0);
        check("rr_post_m1_rdv", a_m1_readdatavalid, 0);
        nxt(); drv(0, 1, 0, 13'h10, 4'hF, 0);
        nxt(); idle();
        @(negedge clk);
        check("rr_again_rdv", a_m0_readdatavalid, 1);
        check("rr_again_data", a_m0_readdata, 32'hDEADBEEF);
        // zero-fill instance: fresh reset, then count sweep cycles
        nxt(); reset = 1'b1;
        nxt(); reset = 1'b0;
        n = 0;
        while (n < 9000) begin
            @(negedge clk);
            if (!b_m0_waitrequest) break;
            n++;
        end
        check("zero_sweep_cycles", 32'(n), 32'd8192);
        nxt(); drv(0, 1, 0, 13'd0, 4'hF, 0);
        @(negedge clk);
        check("zero_accept", b_m0_waitrequest, 0);
        nxt(); drv(0, 1, 0, 13'd4095, 4'hF, 0);
        @(negedge clk);
        check("zero_rdv_0", b_m0_readdatavalid, 1);
        check("zero_data_0", b_m0_readdata, 0);
        nxt(); drv(0, 1, 0, 13'd8191, 4'hF, 0);
        @(negedge clk);
        check("zero_rdv_4095", b_m0_readdatavalid, 1);
        check("zero_data_4095", b_m0_readdata, 0);
        check("nozero_data_4095", a_m0_readdata, pat(4095));
        nxt(); idle();
        @(negedge clk);
        check("zero_rdv_8191", b_m0_readdatavalid, 1);
        check("zero_data_8191", b_m0_readdata, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
